dp_ex_wb_elastic_stage: RTL
===========================

// Module: dp_ex_wb_elastic_stage
// PURPOSE
// - Parametrised EX->WB pipeline stage: generalises the fixed EX/WB register with valid/ready handshake,
//   N writeback address channels, configurable widths and a 2-entry skid buffer.
// - Sits between the EX datapath and the WB/memory interface; lets WB back-pressure EX without a combinational ready path.
// - Keeps the stall/flush control used by the hazard unit.
// PARAMETERS
// - DATA_W   32  width of the result, store-data and next-PC fields
// - ADDR_W   5   width of one register-file address
// - NUM_WB   2   number of writeback address channels; channel k = bits [k*ADDR_W +: ADDR_W]
// - CNT_W    16  width of the perf counters (DP_STAGE_PERF_EN only)
// PORTS
// - clk            in   1              rising-edge clock
// - reset_n        in   1              asynchronous reset, active-low
// - flush          in   1              discard all buffered entries
// - stall          in   1              freeze the output; no handoff downstream
// - in_valid       in   1              EX presents an entry
// - in_ready       out  1              stage can accept an entry; registered
// - in_addr        in   NUM_WB*ADDR_W  destination register addresses
// - in_result      in   DATA_W         ALU result
// - in_store       in   DATA_W         store write data (operand B)
// - in_pc_next     in   DATA_W         next PC
// - out_valid      out  1              WB entry valid
// - out_ready      in   1              WB accepts the entry
// - out_addr       out  NUM_WB*ADDR_W  forced to 0 while out_valid=0
// - out_result     out  DATA_W         main register payload
// - out_store      out  DATA_W         main register payload
// - out_pc_next    out  DATA_W         main register payload
// - perf_stall_cnt out  CNT_W          macro only; cycles with out_valid & !out_fire
// - perf_flush_cnt out  CNT_W          macro only; flush cycles that discarded >=1 valid entry
// BEHAVIOUR
// - Storage: main register (drives the outputs) plus skid register. State is EMPTY, ONE (main full) or TWO (both full).
// - in_fire  = in_valid & in_ready.
// - out_fire = out_valid & out_ready & !stall. stall behaves exactly like out_ready=0.
// - in_ready = 1 in EMPTY and ONE; in_ready = 0 in TWO. Driven from state only; never depends on out_ready.
// - Transitions:
//   - EMPTY: in_fire -> ONE (main<=in).
//   - ONE: in_fire & out_fire -> ONE (main<=in). in_fire & !out_fire -> TWO (skid<=in).
//     !in_fire & out_fire -> EMPTY.
//   - TWO: out_fire -> ONE (main<=skid). Otherwise hold.
// - Latency: 1 cycle from in_fire to out_valid when the stage is not backed up. Strict FIFO order; no entry dropped or duplicated.
// - Payload regs load only on the transfers listed above. Stale payload is allowed; out_addr is gated to 0 when out_valid=0,
//   so forwarding never matches x0 or a bubble.
// - flush (synchronous) has top priority over stall, in_fire and out_fire:
//   - next state EMPTY; all payload regs <= 0.
//   - an in_valid entry presented in that cycle is discarded.
// - Reset (reset_n=0, asynchronous):
//   - state EMPTY, all payload regs 0.
//   - out_valid=0, out_addr=0, out_result/out_store/out_pc_next=0, in_ready=1, counters=0.
//   - Reset mid-transfer discards everything. First acceptance is possible in the first clock edge after release.
// - All arithmetic unsigned. NUM_WB>=1 and ADDR_W>=1 are required; no width extension between fields.
// CONFIGURATION
// - DP_STAGE_PERF_EN defined:
//   - adds perf_stall_cnt and perf_flush_cnt ports.
//   - counters saturate at all-ones, reset to 0, are not cleared by flush.
//   - perf_stall_cnt increments in cycles where out_valid & !out_fire.
// - DP_STAGE_PERF_EN undefined: the ports and counter logic are absent; all other behaviour is identical.
// TESTING
// - Reset: reset_n=0 mid-run with state TWO -> out_valid=0, in_ready=1, out_addr=0 asynchronously; first post-release
//   in_fire appears next cycle.
// - Streaming: out_ready=1, in_valid every cycle with result=1,2,3,... -> out_result=1,2,3,... one cycle later.
//   in_ready stays 1; no gaps.
// - Back-pressure: out_ready=0 for 3 cycles while sending 0xA, 0xB, 0xC:
//   - 0xA and 0xB accepted; in_ready=0 from the cycle after 0xB.
//   - 0xC held upstream.
//   - out_ready=1 -> A, B, C out in order on consecutive cycles.
// - Stall vs ready: state ONE with out_ready=1, stall=1 for 2 cycles -> out_valid=1, payload held, no handoff.
//   Release -> entry consumed once.
// - Flush priority: state TWO, assert flush with in_valid=1 and stall=1 -> next cycle out_valid=0, out_addr=0,
//   in_ready=1, payload 0. The incoming entry is never emitted.
// - Perf (macro on, CNT_W=2): hold out_ready=0 with a valid entry for 5 cycles -> perf_stall_cnt=3 (saturated).
//   Flush of the TWO state -> perf_flush_cnt=1.

Source files
------------

// File: rtl/dp_ex_wb_elastic_stage.sv
// EX->WB elastic pipeline stage: valid/ready handshake with a 2-entry skid buffer and hazard-unit stall/flush.
// Optional perf counters (stall cycles, discarding flushes) when DP_STAGE_PERF_EN is defined.
module dp_ex_wb_elastic_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_WB = 2,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     stall,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_WB*ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0]        in_result,
  input  logic [DATA_W-1:0]        in_store,
  input  logic [DATA_W-1:0]        in_pc_next,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_WB*ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0]        out_result,
  output logic [DATA_W-1:0]        out_store,
`ifdef DP_STAGE_PERF_EN
  output logic [CNT_W-1:0]         perf_stall_cnt,
  output logic [CNT_W-1:0]         perf_flush_cnt,
`endif
  output logic [DATA_W-1:0]        out_pc_next
);

  localparam int AW = NUM_WB * ADDR_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic              in_fire;
  logic              out_fire;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid_in;

  logic [AW-1:0]     main_addr;
  logic [DATA_W-1:0] main_result;
  logic [DATA_W-1:0] main_store;
  logic [DATA_W-1:0] main_pc_next;
  logic [AW-1:0]     skid_addr;
  logic [DATA_W-1:0] skid_result;
  logic [DATA_W-1:0] skid_store;
  logic [DATA_W-1:0] skid_pc_next;

  // Handshake flags come straight from the state register so ready never sees out_ready.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready & ~stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            state_d      = TWO;
            load_skid_in = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // ---- main register: drives the WB outputs ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_addr    <= '0;
      main_result  <= '0;
      main_store   <= '0;
      main_pc_next <= '0;
    end else if (flush) begin
      main_addr    <= '0;
      main_result  <= '0;
      main_store   <= '0;
      main_pc_next <= '0;
    end else if (load_main_in) begin
      main_addr    <= in_addr;
      main_result  <= in_result;
      main_store   <= in_store;
      main_pc_next <= in_pc_next;
    end else if (load_main_skid) begin
      main_addr    <= skid_addr;
      main_result  <= skid_result;
      main_store   <= skid_store;
      main_pc_next <= skid_pc_next;
    end
  end

  // ---- skid register: catches the entry accepted while WB is blocked ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_addr    <= '0;
      skid_result  <= '0;
      skid_store   <= '0;
      skid_pc_next <= '0;
    end else if (flush) begin
      skid_addr    <= '0;
      skid_result  <= '0;
      skid_store   <= '0;
      skid_pc_next <= '0;
    end else if (load_skid_in) begin
      skid_addr    <= in_addr;
      skid_result  <= in_result;
      skid_store   <= in_store;
      skid_pc_next <= in_pc_next;
    end
  end

  // Bubbles present address 0 so forwarding comparators never match them.
  assign out_addr    = out_valid ? main_addr : '0;
  assign out_result  = main_result;
  assign out_store   = main_store;
  assign out_pc_next = main_pc_next;

`ifdef DP_STAGE_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (out_valid && !out_fire) begin
        perf_stall_cnt <= sat_inc(perf_stall_cnt);
      end
      if (flush && out_valid) begin
        perf_flush_cnt <= sat_inc(perf_flush_cnt);
      end
    end
  end
`endif

endmodule
